// File: rtl/pong_pkg.sv
// Shared types and widths for the pong game controller and its frame divider.
package pong_pkg;

  localparam int unsigned STATE_W     = 3;
  localparam int unsigned SCORE_W     = 4;
  localparam int unsigned DIV_W       = 4;
  localparam int unsigned HIT_W       = 4;
  localparam int unsigned SERVE_CNT_W = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  typedef logic [SCORE_W-1:0] score_t;
  typedef logic [DIV_W-1:0]   div_t;

  typedef struct packed {
    score_t l;
    score_t r;
  } score_pair_t;

  // Speed-up step: one frame faster per motion tick, never below one frame.
  function automatic div_t div_step(input div_t d);
    return (d > DIV_W'(1)) ? d - DIV_W'(1) : DIV_W'(1);
  endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Game event inputs and controller outputs between video/ball logic and the controller.
interface pong_game_ctrl_if
  import pong_pkg::*;
  ();

  logic                 frame_start;
  logic                 start_btn;
  logic                 hit_l;
  logic                 hit_r;
  logic                 miss_l;
  logic                 miss_r;
  logic                 update_tick;
  logic                 serve_l;
  logic                 serve_r;
  logic [SCORE_W-1:0]   score_l;
  logic [SCORE_W-1:0]   score_r;
  logic                 game_over;
  logic [STATE_W-1:0]   state;

  modport master (
    output frame_start, start_btn, hit_l, hit_r, miss_l, miss_r,
    input  update_tick, serve_l, serve_r, score_l, score_r, game_over, state
  );

  modport slave (
    input  frame_start, start_btn, hit_l, hit_r, miss_l, miss_r,
    output update_tick, serve_l, serve_r, score_l, score_r, game_over, state
  );

endinterface

// File: rtl/pong_tick_div.sv
// Frame divider: emits tick on the frame_start that completes each divisor-frame period.
module pong_tick_div
  import pong_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  div_t divisor,
  input  logic frame_start,
  output logic tick
);

  div_t cnt_q;

  // Terminal count is 1; a divisor lowered mid-period takes effect on the next reload.
  assign tick = frame_start & ~load & (cnt_q <= DIV_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= divisor;
    end else if (frame_start) begin
      cnt_q <= tick ? divisor : cnt_q - DIV_W'(1);
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencing: start, serve delay, rally speed-up, scoring and game over.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE     = 9,
  parameter int unsigned SERVE_FRAMES  = 60,
  parameter int unsigned TICK_DIV_INIT = 4,
  parameter int unsigned HITS_PER_STEP = 4
) (
  input logic              clk,
  input logic              rst,
  pong_game_ctrl_if.slave  bus
);

  state_e                  state_q, state_n;
  score_pair_t             score_q, score_n;
  logic                    server_r_q, server_r_n;
  logic [SERVE_CNT_W-1:0]  serve_cnt_q, serve_cnt_n;
  logic [HIT_W-1:0]        hit_cnt_q, hit_cnt_n;
  div_t                    tick_div_q, tick_div_n;
  logic                    start_prev_q;

  logic start_edge;
  logic miss_any;
  logic serve_l_c, serve_r_c;
  logic div_load;
  logic div_tick;

  assign start_edge = bus.start_btn & ~start_prev_q;
  assign miss_any   = bus.miss_l | bus.miss_r;

  pong_tick_div u_tick_div (
    .clk         (clk),
    .rst         (rst),
    .load        (div_load),
    .divisor     (tick_div_q),
    .frame_start (bus.frame_start & (state_q == ST_PLAY)),
    .tick        (div_tick)
  );

  // Start history tracks the button even in reset so a held button never retriggers.
  always_ff @(posedge clk) begin
    start_prev_q <= bus.start_btn;
    if (rst) begin
      state_q     <= ST_IDLE;
      score_q     <= '0;
      server_r_q  <= 1'b1;
      serve_cnt_q <= '0;
      hit_cnt_q   <= '0;
      tick_div_q  <= DIV_W'(TICK_DIV_INIT);
    end else begin
      state_q     <= state_n;
      score_q     <= score_n;
      server_r_q  <= server_r_n;
      serve_cnt_q <= serve_cnt_n;
      hit_cnt_q   <= hit_cnt_n;
      tick_div_q  <= tick_div_n;
    end
  end

  always_comb begin
    state_n     = state_q;
    score_n     = score_q;
    server_r_n  = server_r_q;
    serve_cnt_n = serve_cnt_q;
    hit_cnt_n   = hit_cnt_q;
    tick_div_n  = tick_div_q;
    serve_l_c   = 1'b0;
    serve_r_c   = 1'b0;
    div_load    = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_edge) begin
          state_n     = ST_SERVE;
          score_n     = '0;
          server_r_n  = 1'b1;
          serve_cnt_n = '0;
          hit_cnt_n   = '0;
          tick_div_n  = DIV_W'(TICK_DIV_INIT);
        end
      end

      ST_SERVE: begin
        if (bus.frame_start) begin
          if (serve_cnt_q == SERVE_CNT_W'(SERVE_FRAMES - 1)) begin
            serve_l_c   = ~server_r_q;
            serve_r_c   = server_r_q;
            div_load    = 1'b1;
            serve_cnt_n = '0;
            state_n     = ST_PLAY;
          end else begin
            serve_cnt_n = serve_cnt_q + SERVE_CNT_W'(1);
          end
        end
      end

      // A miss pre-empts hits and motion ticks in the same cycle; miss_l wins a double miss.
      ST_PLAY: begin
        if (bus.miss_l) begin
          score_n.r  = score_q.r + SCORE_W'(1);
          server_r_n = 1'b1;
          state_n    = ST_POINT;
        end else if (bus.miss_r) begin
          score_n.l  = score_q.l + SCORE_W'(1);
          server_r_n = 1'b0;
          state_n    = ST_POINT;
        end else if (bus.hit_l | bus.hit_r) begin
          if (hit_cnt_q == HIT_W'(HITS_PER_STEP - 1)) begin
            hit_cnt_n  = '0;
            tick_div_n = div_step(tick_div_q);
          end else begin
            hit_cnt_n = hit_cnt_q + HIT_W'(1);
          end
        end
      end

      ST_POINT: begin
        if ((score_q.l == SCORE_W'(WIN_SCORE)) || (score_q.r == SCORE_W'(WIN_SCORE))) begin
          state_n = ST_OVER;
        end else begin
          state_n     = ST_SERVE;
          serve_cnt_n = '0;
          hit_cnt_n   = '0;
          tick_div_n  = DIV_W'(TICK_DIV_INIT);
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  // Pulses coincide with their triggering input cycle; reset suppresses them immediately.
  assign bus.serve_l     = serve_l_c & ~rst;
  assign bus.serve_r     = serve_r_c & ~rst;
  assign bus.update_tick = div_tick & (state_q == ST_PLAY) & ~miss_any & ~rst;
  assign bus.score_l     = score_q.l;
  assign bus.score_r     = score_q.r;
  assign bus.game_over   = (state_q == ST_OVER);
  assign bus.state       = state_q;

endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 9, points that end a game (1..15).
REQ-002 SHALL have parameter SERVE_FRAMES, default 60, frames waited before each serve (1..255).
REQ-003 SHALL have parameter TICK_DIV_INIT, default 4, frames per motion tick at rally start (1..15).
REQ-004 SHALL have parameter HITS_PER_STEP, default 4, paddle hits per speed-up step (1..15).
REQ-005 SHALL have port clk  in  1  clock (pixel clock).
REQ-006 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-007 SHALL have port frame_start  in  1  one-cycle pulse at start of vertical blank.
REQ-008 SHALL have port start_btn  in  1  debounced start button level.
REQ-009 SHALL have ports hit_l, hit_r  in  1 each  one-cycle ball-hit-paddle pulses.
REQ-010 SHALL have ports miss_l, miss_r  in  1 each  one-cycle ball-passed-paddle pulses.
REQ-011 SHALL have port update_tick  out  1  one-cycle enable for ball/paddle position update.
REQ-012 SHALL have ports serve_l, serve_r  out  1 each  one-cycle serve command to ball logic.
REQ-013 SHALL have ports score_l, score_r  out  4 each  current scores.
REQ-014 SHALL have port game_over  out  1  high while in OVER.
REQ-015 SHALL have port state  out  3  current state encoding (debug).

Function
REQ-016 SHALL implement FSM states IDLE, SERVE, PLAY, POINT, OVER.
REQ-017 SHALL detect start as start_btn rising edge (registered previous level); level held high SHALL NOT retrigger.
REQ-018 IDLE: start edge -> SERVE, scores cleared, server = right.
REQ-019 SERVE: count frame_start pulses; on the SERVE_FRAMES-th pulse assert serve_l or serve_r (per server) for exactly that cycle and enter PLAY next cycle.
REQ-020 On entering PLAY, the frame divider SHALL load the current tick divisor and update_tick SHALL be low.
REQ-021 PLAY: update_tick SHALL pulse on the frame_start cycle on which the divider reaches its terminal count, i.e. once every tick-divisor frames.
REQ-022 PLAY: each hit_l or hit_r pulse increments the rally hit counter; at HITS_PER_STEP the counter clears and the tick divisor decrements, saturating at 1.
REQ-023 PLAY: miss_l -> score_r+1, server = right, enter POINT; miss_r -> score_l+1, server = left, enter POINT.
REQ-024 Simultaneous miss_l and miss_r SHALL be treated as miss_l only.
REQ-025 A miss SHALL take priority over a same-cycle frame_start: no update_tick in that cycle.
REQ-026 A same-cycle hit and miss SHALL count the miss only.
REQ-027 POINT (one cycle): if either score equals WIN_SCORE -> OVER, else -> SERVE with tick divisor reloaded to TICK_DIV_INIT and hit counter cleared.
REQ-028 OVER: scores frozen; game_over=1; start edge -> SERVE with scores cleared, server = right.
REQ-029 hit/miss pulses outside PLAY and frame_start outside SERVE/PLAY SHALL be ignored.
REQ-030 Scores SHALL never exceed WIN_SCORE; arithmetic is 4-bit unsigned.

Reset
REQ-031 rst SHALL force state=IDLE, score_l=score_r=0, game_over=0, update_tick=0, serve_l=serve_r=0, tick divisor=TICK_DIV_INIT, all counters 0, server=right.
REQ-032 rst asserted mid-game SHALL abort any state on the next clock edge with no serve or tick pulse emitted.

Structure
REQ-033 State encoding and score/divisor widths SHALL live in shared package pong_pkg.
REQ-034 The frame divider SHALL be a sub-module pong_tick_div (load, divisor, frame_start in; tick out).

Verification
REQ-035 Reset, start edge, 60 frame_start pulses -> serve_r single pulse on 60th pulse, state=PLAY next cycle.
REQ-036 PLAY with divisor 4, 12 frame_start pulses -> exactly 3 update_tick pulses, aligned to frame_start.
REQ-037 8 hits with HITS_PER_STEP=4 -> divisor 4->2; 20 further hits -> saturates at 1, update_tick every frame.
REQ-038 miss_r nine times (each after a serve) -> score_l=9, game_over=1; further miss ignored; start edge -> scores 0, SERVE.
REQ-039 miss_l and miss_r plus frame_start in same cycle -> score_r+1 only, no update_tick, state=POINT.
REQ-040 rst pulse during SERVE frame count -> IDLE, scores 0, no serve pulse afterwards without new start edge.
